clk_div_gen: RTL and testbench

Generates the medium- and slow-rate clocks for the waveform sample's `sub` instances from the single fast clock, so the three clock domains are phase-related and reprogrammable. Two independent divider channels produce 50%-duty divided clocks and single-cycle rising-edge ticks. A valid/ready config port retunes either divisor. Each change is applied glitch-free at that channel's next rising edge. The block sits directly upstream of the `sub` instances and drives their `clk` ports.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_chan.sv | 61 ++++++
 rtl/clk_div_gen.sv | 88 ++++++++
 tb/tb_clk_div_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : clk_div_pkg
// Brief  : Shared constants and divisor legality check for clk_div_gen.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_DIV_MED  = 100;
  localparam int DEF_DIV_SLOW = 1000;

  localparam logic SEL_MED  = 1'b0;
  localparam logic SEL_SLOW = 1'b1;

  // A divisor must split into two equal non-empty phases.
  function automatic logic is_legal_div(input logic [31:0] d);
    return (d[0] == 1'b0) && (d >= 32'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : clk_div_chan
// Brief  : One 50%-duty divider channel; swaps divisor only on its 0->1 toggle.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module clk_div_chan #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_req,
  input  logic [CNT_W-1:0] commit_div,
  output logic             out,
  output logic             tick,
  output logic             commit_ack
);

  localparam logic [CNT_W-1:0] c_div_rst = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;
  logic [CNT_W-1:0] w_half_m1;
  logic             w_wrap;
  logic             w_rise;

  assign w_half_m1  = (r_div >> 1) - c_one;
  assign w_wrap     = (r_cnt == w_half_m1);
  assign w_rise     = w_wrap && !r_out;
  // New divisor takes effect exactly at a rising edge so no phase is cut short.
  assign commit_ack = w_rise && commit_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= c_div_rst;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_rise;
      if (w_wrap) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
      if (commit_ack) begin
        r_div <= commit_div;
      end
    end
  end

  assign out  = r_out;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : clk_div_gen
// Brief  : Medium/slow divided clocks with a single-slot reprogramming port.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W            = DEF_CNT_W,
  parameter int DIV_MED_DEFAULT  = DEF_DIV_MED,
  parameter int DIV_SLOW_DEFAULT = DEF_DIV_SLOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             med_clk,
  output logic             slow_clk,
  output logic             med_tick,
  output logic             slow_tick
);

  logic             r_pend_vld;
  logic             r_pend_sel;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_err;
  logic             w_accept;
  logic             w_legal;
  logic             w_med_ack;
  logic             w_slow_ack;

  assign cfg_ready = !r_pend_vld && !rst;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_legal   = is_legal_div(32'(cfg_div));

  // Accept needs an empty slot and a commit needs a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_sel <= SEL_MED;
      r_pend_div <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_pend_vld <= 1'b1;
        r_pend_sel <= cfg_sel;
        r_pend_div <= cfg_div;
      end else if (w_med_ack || w_slow_ack) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign cfg_err = r_err;

  clk_div_chan #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_MED_DEFAULT)
  ) u_med (
    .clk        (clk),
    .rst        (rst),
    .commit_req (r_pend_vld && (r_pend_sel == SEL_MED)),
    .commit_div (r_pend_div),
    .out        (med_clk),
    .tick       (med_tick),
    .commit_ack (w_med_ack)
  );

  clk_div_chan #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_SLOW_DEFAULT)
  ) u_slow (
    .clk        (clk),
    .rst        (rst),
    .commit_req (r_pend_vld && (r_pend_sel == SEL_SLOW)),
    .commit_div (r_pend_div),
    .out        (slow_clk),
    .tick       (slow_tick),
    .commit_ack (w_slow_ack)
  );

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_clk_div_gen
// Brief  : Randomised bench for clk_div_gen against a rise-time event model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_clk_div_gen;

  localparam int CNT_W    = 16;
  localparam int DIV_MED  = 100;
  localparam int DIV_SLOW = 1000;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_sel   = 1'b0;
  logic [CNT_W-1:0] cfg_div   = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             med_clk;
  logic             slow_clk;
  logic             med_tick;
  logic             slow_tick;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic mclk;
    logic mtick;
    logic sclk;
    logic stick;
    logic pend_empty;
    logic err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  clk_div_gen #(
    .CNT_W            (CNT_W),
    .DIV_MED_DEFAULT  (DIV_MED),
    .DIV_SLOW_DEFAULT (DIV_SLOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .med_clk   (med_clk),
    .slow_clk  (slow_clk),
    .med_tick  (med_tick),
    .slow_tick (slow_tick)
  );

  // Reference model: each channel is a list of rise times; level follows from
  // the distance to the last rise, and a pending divisor is swapped in at a rise.
  int   m_n;
  int   m_defs[2] = '{DIV_MED, DIV_SLOW};
  int   m_div[2];
  int   m_last[2];
  int   m_next[2];
  bit   m_lvl[2];
  bit   m_tk[2];
  bit   m_pend;
  int   m_pend_sel;
  int   m_pend_div;
  bit   m_acc;
  bit   m_legal;
  exp_t m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_n    = 0;
      m_pend = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_div[c]  = m_defs[c];
        m_next[c] = m_defs[c] / 2;
        m_last[c] = -(m_defs[c] / 2);
        m_lvl[c]  = 1'b0;
        m_tk[c]   = 1'b0;
      end
      m_acc   = 1'b0;
      m_legal = 1'b1;
    end else begin
      m_n++;
      m_acc   = cfg_valid && !m_pend;
      m_legal = (int'(cfg_div) % 2 == 0) && (int'(cfg_div) >= 2);
      for (int c = 0; c < 2; c++) begin
        m_tk[c] = 1'b0;
        if (m_n == m_next[c]) begin
          m_tk[c] = 1'b1;
          if (m_pend && m_pend_sel == c) begin
            m_div[c] = m_pend_div;
            m_pend   = 1'b0;
          end
          m_last[c] = m_n;
          m_next[c] = m_n + m_div[c];
        end
        m_lvl[c] = (m_n - m_last[c]) < (m_div[c] / 2);
      end
      if (m_acc && m_legal) begin
        m_pend     = 1'b1;
        m_pend_sel = int'(cfg_sel);
        m_pend_div = int'(cfg_div);
      end
    end
    m_e.mclk       = m_lvl[0];
    m_e.mtick      = m_tk[0];
    m_e.sclk       = m_lvl[1];
    m_e.stick      = m_tk[1];
    m_e.pend_empty = !m_pend;
    m_e.err        = m_acc && !m_legal;
    exp_q.push_back(m_e);
  end

  // Monitor: one expected record per clock, compared mid-cycle.
  exp_t       mon_e;
  logic [5:0] mon_act;
  logic [5:0] mon_exp;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_exp = {mon_e.mclk, mon_e.mtick, mon_e.sclk, mon_e.stick,
                 mon_e.pend_empty && !rst, mon_e.err};
      mon_act = {med_clk, med_tick, slow_clk, slow_tick, cfg_ready, cfg_err};
      compared++;
      if (mon_act !== mon_exp) begin
        mismatched++;
        $display("FAIL outputs @%0t: {mclk,mtick,sclk,stick,ready,err} got %b required %b",
                 $time, mon_act, mon_exp);
      end
    end
  end

  task automatic run_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic s, input int d);
    int guard;
    guard     = 0;
    cfg_valid = 1'b1;
    cfg_sel   = s;
    cfg_div   = CNT_W'(d);
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      guard++;
      if (guard > 5000) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout: cfg_ready got %b required 1", cfg_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_med_high();
    int guard;
    guard = 0;
    while (med_clk !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (med_clk !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL med_high_timeout: med_clk got %b required 1", med_clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    run_cycles(3);
    rst = 1'b0;

    // Defaults free-run.
    run_cycles(2000);

    // Medium retune to 10 ahead of the 150 rise.
    pulse_rst();
    run_cycles(119);
    send(1'b0, 10);
    run_cycles(200);

    // Illegal divisors.
    send(1'b0, 7);
    send(1'b0, 0);
    send(1'b1, 7);
    run_cycles(50);

    // Back-to-back: the second request stalls behind the slow commit.
    send(1'b1, 200);
    send(1'b0, 20);
    run_cycles(600);

    // Reset while a write is pending and med_clk is high.
    send(1'b1, 400);
    wait_med_high();
    pulse_rst();
    run_cycles(300);

    // Minimum divisor.
    send(1'b1, 2);
    run_cycles(100);

    for (int i = 0; i < 80; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 15));
      run_cycles(int'($urandom_range(1, 30)));
      if (r == 0) begin
        pulse_rst();
      end else begin
        case (r)
          1:       d = 2 * int'($urandom_range(0, 30)) + 1;
          2:       d = 0;
          3:       d = 2;
          default: d = 2 * int'($urandom_range(1, 30));
        endcase
        send(1'($urandom_range(0, 1)), d);
      end
    end

    run_cycles(200);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
